// File: rtl/sig_sched_pkg.sv
// Shared state encoding and data widths for the signature output scheduler.
// Imported by sig_rr_pick and sig_output_scheduler.
package sig_sched_pkg;

    localparam int SIG_W  = 520;
    localparam int HASH_W = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sig_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping past the top index.
module sig_rr_pick
    import sig_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    int j;

    // Walk offsets from the top down so the smallest offset wins last.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                grant   = IDX_W'(j);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sig_output_scheduler.sv
// Round-robin scheduler sharing one signature output formatter among requesters.
// Define SIG_SCHED_TIMEOUT_EN to add the BUSY-state timeout counter.
module sig_output_scheduler
    import sig_sched_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  TIMEOUT_CYC = 64,
    localparam int IDX_W       = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*SIG_W-1:0]  req_sig,
    input  logic [NUM_REQ*HASH_W-1:0] req_hash,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [SIG_W-1:0]          fmt_sig,
    output logic [HASH_W-1:0]         fmt_hash,
    output logic                      fmt_sig_valid,
    output logic                      fmt_format_output,
    input  logic                      fmt_output_ready,
    input  logic                      fmt_output_error,
    output logic                      done_valid,
    output logic [IDX_W-1:0]          done_id,
    output logic                      done_error,
    output logic                      busy
);

    sched_state_e      state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [SIG_W-1:0]  sig_q;
    logic [HASH_W-1:0] hash_q;
    logic              err_q;
    logic              issue_q;
    logic              expire;

    sig_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (pick_idx),
        .any_req (pick_any)
    );

`ifdef SIG_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    assign expire = (state == S_BUSY) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= '0;
        end else if (state == S_BUSY) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            idx_q      <= '0;
            sig_q      <= '0;
            hash_q     <= '0;
            err_q      <= 1'b0;
            issue_q    <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_error <= 1'b0;
            req_ack    <= '0;
        end else begin
            issue_q    <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_error <= 1'b0;
            req_ack    <= '0;
            unique case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        idx_q   <= pick_idx;
                        sig_q   <= req_sig[SIG_W*pick_idx +: SIG_W];
                        hash_q  <= req_hash[HASH_W*pick_idx +: HASH_W];
                        err_q   <= 1'b0;
                        issue_q <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    // Ready wins over a coincident timeout.
                    if (fmt_output_error || (expire && !fmt_output_ready))
                        err_q <= 1'b1;
                    if (fmt_output_ready || expire) begin
                        state      <= S_DONE;
                        done_valid <= 1'b1;
                        done_id    <= idx_q;
                        done_error <= err_q | fmt_output_error
                                    | (expire & ~fmt_output_ready);
                        req_ack    <= NUM_REQ'(1) << idx_q;
                    end
                end
                S_DONE: begin
                    rr_ptr <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fmt_sig           = sig_q;
    assign fmt_hash          = hash_q;
    assign fmt_sig_valid     = issue_q;
    assign fmt_format_output = issue_q;
    assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_sig_output_scheduler.sv
// Self-checking bench for sig_output_scheduler: directed table, timeout and
// reset sequences, then randomized jobs against a round-robin reference model.
module tb_sig_output_scheduler;
    import sig_sched_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*SIG_W-1:0]  req_sig;
    logic [N*HASH_W-1:0] req_hash;
    logic [N-1:0]      req_ack;
    logic [SIG_W-1:0]  fmt_sig;
    logic [HASH_W-1:0] fmt_hash;
    logic              fmt_sig_valid;
    logic              fmt_format_output;
    logic              fmt_output_ready = 1'b0;
    logic              fmt_output_error = 1'b0;
    logic              done_valid;
    logic [1:0]        done_id;
    logic              done_error;
    logic              busy;

    logic [SIG_W-1:0]  sig_a  [N];
    logic [HASH_W-1:0] hash_a [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_sig[g*SIG_W +: SIG_W]    = sig_a[g];
        assign req_hash[g*HASH_W +: HASH_W] = hash_a[g];
    end

    sig_output_scheduler #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_sig           (req_sig),
        .req_hash          (req_hash),
        .req_ack           (req_ack),
        .fmt_sig           (fmt_sig),
        .fmt_hash          (fmt_hash),
        .fmt_sig_valid     (fmt_sig_valid),
        .fmt_format_output (fmt_format_output),
        .fmt_output_ready  (fmt_output_ready),
        .fmt_output_error  (fmt_output_error),
        .done_valid        (done_valid),
        .done_id           (done_id),
        .done_error        (done_error),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int m_ptr  = 0;

`ifdef SIG_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] mask;
        int           lat;
        int           err_at;
        int           exp_id;
        bit           exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [SIG_W-1:0] act,
                       input logic [SIG_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SIG_W-1:0] rand_sig();
        logic [SIG_W-1:0] r = '0;
        for (int i = 0; i < 17; i++) r = {r[SIG_W-33:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [HASH_W-1:0] rand_hash();
        logic [HASH_W-1:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[HASH_W-33:0], 32'($urandom)};
        return r;
    endfunction

    // Reference: first requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int model_exit(input int lat);
        return (TO_EN && lat > TO - 1) ? TO - 1 : lat;
    endfunction

    function automatic bit model_err(input int lat, input int err_at);
        int ex = model_exit(lat);
        return (TO_EN && lat > TO - 1) || (err_at >= 0 && err_at <= ex);
    endfunction

    // Called in an IDLE cycle with req_valid already driven.
    task automatic run_job(input string tag, input int exp_id, input int lat,
                           input int err_at, input bit exp_err, input bit noise);
        logic [SIG_W-1:0]  es = sig_a[exp_id];
        logic [HASH_W-1:0] eh = hash_a[exp_id];
        int ex = model_exit(lat);
        int bad = 0;
        step();
        chk({tag, " issue"}, {fmt_format_output, fmt_sig_valid, busy}, 3'b111);
        chk({tag, " sig"}, fmt_sig, es);
        chk({tag, " hash"}, fmt_hash, eh);
        fmt_output_ready = noise;
        for (int k = 0; k <= ex; k++) begin
            step();
            bad += int'(fmt_format_output) + int'(done_valid) + int'(!busy);
            if (fmt_sig !== es || fmt_hash !== eh) bad++;
            fmt_output_ready = (k == lat);
            fmt_output_error = (k == err_at);
            if (noise) begin
                sig_a[exp_id]  = rand_sig();
                hash_a[exp_id] = rand_hash();
                if (k == 0) req_valid[exp_id] = 1'b0;
            end
        end
        chk({tag, " busy quiet"}, bad, 0);
        step();
        fmt_output_ready = 1'b0;
        fmt_output_error = 1'b0;
        chk({tag, " done"}, {done_valid, busy}, 2'b11);
        chk({tag, " done_id"}, done_id, exp_id);
        chk({tag, " done_error"}, done_error, exp_err);
        chk({tag, " ack"}, req_ack, N'(1) << exp_id);
        chk({tag, " done sig"}, fmt_sig, es);
        step();
        chk({tag, " idle"}, {done_valid, req_ack, busy, fmt_format_output}, '0);
        m_ptr = (exp_id + 1) % N;
    endtask

    vec_t tbl [10];

    initial begin
        int bad;
        logic [SIG_W-1:0] es;

        tbl[0] = '{4'b1111, 0, -1, 0, 1'b0};
        tbl[1] = '{4'b1111, 3, -1, 1, 1'b0};
        tbl[2] = '{4'b1111, 1, -1, 2, 1'b0};
        tbl[3] = '{4'b1111, 2, -1, 3, 1'b0};
        tbl[4] = '{4'b1111, 0, -1, 0, 1'b0};
        tbl[5] = '{4'b0001, 15, -1, 0, 1'b0};
        tbl[6] = '{4'b0100, 5, 2, 2, 1'b1};
        tbl[7] = '{4'b1010, 4, 4, 3, 1'b1};
        tbl[8] = '{4'b1010, 0, -1, 1, 1'b0};
        tbl[9] = '{4'b0011, 2, -1, 0, 1'b0};

        for (int i = 0; i < N; i++) begin
            sig_a[i]  = rand_sig();
            hash_a[i] = rand_hash();
        end

        step();
        step();
        chk("reset outs", {req_ack, fmt_sig_valid, fmt_format_output,
                           done_valid, done_id, done_error, busy}, '0);
        chk("reset sig", fmt_sig, '0);
        chk("reset hash", fmt_hash, '0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].mask;
            run_job($sformatf("vec%0d", i), tbl[i].exp_id, tbl[i].lat,
                    tbl[i].err_at, tbl[i].exp_err, 1'b0);
        end
        req_valid = '0;

        // Formatter ready while idle must not start or finish anything.
        fmt_output_ready = 1'b1;
        step();
        fmt_output_ready = 1'b0;
        step();
        chk("idle ready ignored", {done_valid, req_ack, busy}, '0);

        // Formatter never ready.
        req_valid = 4'b0100;
        if (TO_EN) begin
            run_job("timeout", model_pick(req_valid, m_ptr), 1000, -1, 1'b1, 1'b0);
            req_valid = 4'b1000;
            run_job("ready at limit", model_pick(req_valid, m_ptr), TO - 1, -1,
                    1'b0, 1'b0);
        end else begin
            step();
            bad = 0;
            for (int k = 0; k < 100; k++) begin
                step();
                bad += int'(!busy) + int'(done_valid);
            end
            chk("no timeout busy", bad, 0);
            fmt_output_ready = 1'b1;
            step();
            fmt_output_ready = 1'b0;
            chk("late ready done", {done_valid, done_error, req_ack}, {2'b10, 4'b0100});
            step();
            m_ptr = 3;
        end
        req_valid = '0;
        step();

        // Reset mid-BUSY abandons the job and restarts the pointer.
        req_valid = 4'b0010;
        es = sig_a[1];
        step();
        step();
        step();
        sig_a[1] = rand_sig();
        req_valid = 4'b1111;
        step();
        chk("busy sig held", fmt_sig, es);
        rst_n = 1'b0;
        req_valid = '0;
        step();
        chk("midjob reset outs", {req_ack, fmt_sig_valid, fmt_format_output,
                                  done_valid, done_id, done_error, busy}, '0);
        chk("midjob reset sig", fmt_sig, '0);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            fmt_output_ready = (k == 2);
            step();
            bad += int'(done_valid) + int'(|req_ack) + int'(busy);
        end
        fmt_output_ready = 1'b0;
        chk("no ack after reset", bad, 0);
        m_ptr = 0;
        req_valid = 4'b1111;
        run_job("post reset", model_pick(req_valid, m_ptr), 1, -1, 1'b0, 1'b0);

        // Randomized jobs checked against the reference model.
        for (int i = 0; i < 40; i++) begin
            int lat;
            int ea;
            int id;
            for (int r = 0; r < N; r++) begin
                sig_a[r]  = rand_sig();
                hash_a[r] = rand_hash();
            end
            req_valid = N'($urandom_range(1, 15));
            lat = $urandom_range(0, 20);
            if (TO_EN && $urandom_range(0, 7) == 0)
                lat = ($urandom_range(0, 1) == 1) ? TO - 1 : 500;
            ea = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            id = model_pick(req_valid, m_ptr);
            run_job($sformatf("rnd%0d", i), id, lat, ea, model_err(lat, ea),
                    1'($urandom_range(0, 1)));
        end
        req_valid = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sig_output_scheduler.md
SIG_OUTPUT_SCHEDULER -- requirements
Module: sig_output_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of signing requesters sharing one signature output formatter.
REQ-002 Parameter TIMEOUT_CYC, default 64, maximum cycles in BUSY before forced completion.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester signature-ready request, held until req_ack.
REQ-006 req_sig  input  NUM_REQ*520  per-requester {r,s,v}, slot i at bits [520*i+519:520*i].
REQ-007 req_hash  input  NUM_REQ*256  per-requester message hash, slot i at bits [256*i+255:256*i].
REQ-008 req_ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 fmt_sig, fmt_hash  output  520, 256  formatter signature and hash inputs.
REQ-010 fmt_sig_valid, fmt_format_output  output  1, 1  formatter start qualifiers.
REQ-011 fmt_output_ready, fmt_output_error  input  1, 1  formatter status.
REQ-012 done_valid  output  1  one-cycle job-complete pulse; done_id  output  clog2(NUM_REQ)  served requester; done_error  output  1  job failed.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, ISSUE, BUSY, DONE; encoding 2 bits.
REQ-015 IDLE: any req_valid -> latch winner index, its req_sig and req_hash into internal registers, clear error flag, go ISSUE; else stay.
REQ-016 Winner is round-robin: first asserted index searching upward (wrapping) from rr_ptr; rr_ptr resets to 0.
REQ-017 ISSUE (exactly 1 cycle): fmt_format_output=1, fmt_sig_valid=1; next state BUSY, timeout counter cleared to 0.
REQ-018 fmt_sig/fmt_hash driven from latched registers in ISSUE, BUSY and DONE; stable for the whole job regardless of req_* changes.
REQ-019 fmt_format_output and fmt_sig_valid are 0 in all states except ISSUE.
REQ-020 BUSY: fmt_output_error high in any cycle sets the sticky error flag; fmt_output_ready high -> DONE.
REQ-021 BUSY: counter increments each cycle; counter reaching TIMEOUT_CYC-1 without fmt_output_ready -> DONE with error flag set.
REQ-022 fmt_output_ready and timeout in the same cycle: treated as ready; error flag not set by timeout.
REQ-023 DONE (exactly 1 cycle): done_valid=1, done_id=latched index, done_error=error flag, req_ack[index]=1; rr_ptr <= index+1 (mod NUM_REQ); next IDLE.
REQ-024 Minimum request-to-ack latency 3 cycles plus formatter latency; back-to-back jobs separated by one IDLE cycle.
REQ-025 Requester dropping req_valid mid-job: job completes normally and ack still issued.
REQ-026 fmt_output_ready outside BUSY is ignored.

Reset
REQ-027 rst_n low at a clock edge: state IDLE, rr_ptr 0, counter 0, latched data 0, error flag 0, all outputs 0; an in-flight job is abandoned without ack.

Configuration
REQ-028 Macro SIG_SCHED_TIMEOUT_EN defined: timeout counter and REQ-021/022 present.
REQ-029 SIG_SCHED_TIMEOUT_EN undefined: no counter logic, BUSY exits only on fmt_output_ready; TIMEOUT_CYC unused.

Structure
REQ-030 Package sig_sched_pkg holds state encoding, SIG_W=520, HASH_W=256 constants.
REQ-031 One sub-module sig_rr_pick: combinational round-robin picker (req vector, ptr -> grant index, any_req).

Verification
REQ-032 Single req_valid=0001, formatter ready 16 cycles after start -> one fmt_format_output pulse, done_id=0, done_error=0, req_ack=0001 once.
REQ-033 req_valid=1111 held for four jobs from reset -> grant order 0,1,2,3, then 0 again on fifth.
REQ-034 fmt_output_error pulsed in BUSY then fmt_output_ready -> done_error=1, ack still issued.
REQ-035 Formatter never ready, TIMEOUT_CYC=64 with macro -> DONE after 64 BUSY cycles, done_error=1; without macro -> busy stays high.
REQ-036 req_sig changed and rst_n pulsed low mid-BUSY -> fmt_sig unchanged until reset, then all outputs 0, state IDLE, no ack.
